// File: rtl/ext_mem_reader.sv
// ext_mem_reader
//   Fetches one 8x4 pixel tile (two horizontally adjacent 4x4 blocks) from the
//   external frame store via ext_mem_hub as four 2-word bursts, one per row,
//   then presents the left and right blocks on two consecutive valid pulses.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   global enable; gates state advance (not word capture)
//   start                 request pulse, sampled in IDLE only
//   pic_num_2to0          frame-store slot
//   pic_width_in_mbs      picture width in MBs
//   pic_height_in_map_units picture height in MBs
//   comp                  0 luma, 1 cb, 2/3 cr
//   tile_x, tile_y        tile column (8 px units), tile row (4 row units)
//   busy                  high from accepted start through last output cycle
//   out_valid, out_blk    output pulse, 0 = left block / 1 = right block
//   out_0..out_15         block pixels, raster order
//   ext_mem_reader_*      hub burst request / read-return interface
`ifndef EXT_BUF_MEM_ADDR_WIDTH
`define EXT_BUF_MEM_ADDR_WIDTH 32
`endif
`ifndef MB_X_BITS
`define MB_X_BITS 8
`endif
`ifndef MB_Y_BITS
`define MB_Y_BITS 8
`endif

module ext_mem_reader (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  input  logic                               start,
  input  logic [2:0]                         pic_num_2to0,
  input  logic [`MB_X_BITS-1:0]              pic_width_in_mbs,
  input  logic [`MB_Y_BITS-1:0]              pic_height_in_map_units,
  input  logic [1:0]                         comp,
  input  logic [`MB_X_BITS:0]                tile_x,
  input  logic [`MB_Y_BITS+1:0]              tile_y,
  output logic                               busy,
  output logic                               out_valid,
  output logic                               out_blk,
  output logic [7:0]                         out_0,
  output logic [7:0]                         out_1,
  output logic [7:0]                         out_2,
  output logic [7:0]                         out_3,
  output logic [7:0]                         out_4,
  output logic [7:0]                         out_5,
  output logic [7:0]                         out_6,
  output logic [7:0]                         out_7,
  output logic [7:0]                         out_8,
  output logic [7:0]                         out_9,
  output logic [7:0]                         out_10,
  output logic [7:0]                         out_11,
  output logic [7:0]                         out_12,
  output logic [7:0]                         out_13,
  output logic [7:0]                         out_14,
  output logic [7:0]                         out_15,
  output logic                               ext_mem_reader_burst,
  output logic [4:0]                         ext_mem_reader_burst_len_minus1,
  input  logic                               ext_mem_reader_ready,
  output logic [`EXT_BUF_MEM_ADDR_WIDTH-1:0] ext_mem_reader_addr,
  input  logic [31:0]                        ext_mem_reader_rd_data,
  input  logic                               ext_mem_reader_rd_valid
);

  localparam int AW = `EXT_BUF_MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT0, OUT1} state_t;

  state_t          state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      beat_q, beat_d;     // words captured for current row (saturates at 2)
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   stride_q, stride_d;
  logic [127:0]    left_q, left_d;     // word r of a block at [32r +: 32]
  logic [127:0]    right_q, right_d;
  logic [127:0]    pix_q, pix_d;

  // Address map for the request currently on the inputs
  logic [AW-1:0] w_a, h_a, wh, pic_a, base_c, stride_c, tile_base_c;

  always_comb begin
    w_a   = AW'(pic_width_in_mbs);
    h_a   = AW'(pic_height_in_map_units);
    pic_a = AW'(pic_num_2to0);
    wh    = w_a * h_a;
    base_c   = pic_a * (wh * AW'(384));
    stride_c = w_a << 3;
    case (comp)
      2'd0:    begin base_c = base_c;                   stride_c = w_a << 4; end
      2'd1:    base_c = base_c + wh * AW'(256);
      default: base_c = base_c + wh * AW'(320);
    endcase
    tile_base_c = base_c + ((AW'(tile_y) * stride_c) << 2) + (AW'(tile_x) << 3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      beat_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      left_q   <= '0;
      right_q  <= '0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      left_q   <= left_d;
      right_q  <= right_d;
      pix_q    <= pix_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    beat_d   = beat_q;
    base_d   = base_q;
    stride_d = stride_q;
    left_d   = left_q;
    right_d  = right_q;
    pix_d    = pix_q;

    // Word capture runs regardless of ena so returning beats are never lost
    if (state_q == WAIT && ext_mem_reader_rd_valid && beat_q != 2'd2) begin
      if (beat_q == 2'd0) left_d[{row_q, 5'b0} +: 32]  = ext_mem_reader_rd_data;
      else                right_d[{row_q, 5'b0} +: 32] = ext_mem_reader_rd_data;
      beat_d = beat_q + 2'd1;
    end

    case (state_q)
      IDLE: if (start && ena) begin
        state_d  = REQ;
        row_d    = '0;
        base_d   = tile_base_c;
        stride_d = stride_c;
      end
      REQ: if (ena && ext_mem_reader_ready) begin
        state_d = WAIT;
        beat_d  = '0;
      end
      // Leave on the cycle beat 1 arrives, or later if ena held us after both beats
      WAIT: if (ena && (beat_q == 2'd2 || (ext_mem_reader_rd_valid && beat_q == 2'd1))) begin
        if (row_q == 2'd3) begin
          state_d = OUT0;
          pix_d   = left_q;
        end else begin
          state_d = REQ;
          row_d   = row_q + 2'd1;
        end
      end
      OUT0: if (ena) begin
        state_d = OUT1;
        pix_d   = right_q;
      end
      OUT1: if (ena) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A frozen output state must not repeat its pulse, hence the ena gating
  assign busy      = (state_q != IDLE);
  assign out_valid = ena && (state_q == OUT0 || state_q == OUT1);
  assign out_blk   = ena && (state_q == OUT1);

  assign ext_mem_reader_burst            = (state_q == REQ);
  assign ext_mem_reader_burst_len_minus1 = (state_q == REQ) ? 5'd1 : 5'd0;
  assign ext_mem_reader_addr             = (state_q == REQ) ? base_q + stride_q * AW'(row_q) : '0;

  assign out_0  = pix_q[7:0];
  assign out_1  = pix_q[15:8];
  assign out_2  = pix_q[23:16];
  assign out_3  = pix_q[31:24];
  assign out_4  = pix_q[39:32];
  assign out_5  = pix_q[47:40];
  assign out_6  = pix_q[55:48];
  assign out_7  = pix_q[63:56];
  assign out_8  = pix_q[71:64];
  assign out_9  = pix_q[79:72];
  assign out_10 = pix_q[87:80];
  assign out_11 = pix_q[95:88];
  assign out_12 = pix_q[103:96];
  assign out_13 = pix_q[111:104];
  assign out_14 = pix_q[119:112];
  assign out_15 = pix_q[127:120];

endmodule

// File: doc/ext_mem_reader.md
Name: ext_mem_reader

Overview:
Fetches reconstructed 4x4 pixel blocks back out of the external frame store through ext_mem_hub. It is the read-side counterpart of the block writer and uses the same frame/plane address map. Each request fetches one 8x4 tile, which is two horizontally adjacent 4x4 blocks, as four 2-word bursts. It then presents the two blocks as 16 pixels each, on two consecutive valid cycles. It feeds inter prediction and any consumer needing stored pixels.

Parameters:
none; address width = `ext_buf_mem_addr_width, data width fixed 32 (`ext_buf_mem_data_width_32 only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; gates state advance
start  in  1  request pulse, sampled in IDLE only
pic_num_2to0  in  3  frame-store slot
pic_width_in_mbs  in  `mb_x_bits  picture width, MBs
pic_height_in_map_units  in  `mb_y_bits  picture height, MBs
comp  in  2  0 luma, 1 cb, 2 cr (3 treated as cr)
tile_x  in  `mb_x_bits+1  tile column, units of 8 pixels
tile_y  in  `mb_y_bits+2  tile row, units of 4 rows
busy  out  1  high from accepted start through last output cycle
out_valid  out  1  one-cycle pulse per output block
out_blk  out  1  0 = left block, 1 = right block
out_0..out_15  out  8 each  block pixels, raster order (out_0 top-left, out_3 top-right)
ext_mem_reader_burst  out  1  burst request strobe
ext_mem_reader_burst_len_minus1  out  5  constant 1
ext_mem_reader_ready  in  1  hub accepts burst when high
ext_mem_reader_addr  out  `ext_buf_mem_addr_width  byte address of burst
ext_mem_reader_rd_data  in  32  returned word
ext_mem_reader_rd_valid  in  1  returned-word strobe

Behaviour:
- Reset values: busy, out_valid, out_blk, out_*, burst, addr = 0.
- Byte-address map; F = W*H*384, where W = pic_width_in_mbs and H = pic_height_in_map_units.
  - Luma: base = pic*F, stride S = W*16.
  - Cb: base = pic*F + W*H*256, S = W*8.
  - Cr: base = pic*F + W*H*320, S = W*8.
- Start latch: on accepted start, register tile_base = base + tile_y*4*S + tile_x*8 and S.
- Burst address: burst r (r = 0..3) uses addr = tile_base + r*S.
- No clamping is applied. Out-of-picture tiles are the caller's responsibility.
- States: IDLE, REQ, WAIT, OUT0, OUT1. State advances only when ena=1.
  - IDLE: start & ena -> REQ, row=0, busy=1.
  - REQ: burst=1 and addr driven combinationally from registered state. If ready=1 the burst is accepted -> WAIT, beat=0. If ready=0, burst and addr are held until accepted.
  - WAIT: each rd_valid captures a word, and capture is not gated by ena.
    - Beat 0 -> left block row r; beat 1 -> right block row r.
    - Within a word, byte0 = leftmost pixel: out_{4r+0} = [7:0] ... out_{4r+3} = [31:24].
    - After beat 1: if row<3 -> REQ with row+1, else -> OUT0. The next burst is issued no earlier than the cycle after beat 1, so at most one burst is outstanding.
  - OUT0: out_valid=1, out_blk=0, left pixels -> OUT1.
  - OUT1: out_valid=1, out_blk=1, right pixels -> IDLE; busy drops the following cycle.
- There is no backpressure on the output side. out_* hold their last values between pulses.
- Minimum latency, with ready=1 and data returned on the two cycles after acceptance:
  - start at cycle 0 -> bursts at cycles 1, 4, 7, 10;
  - out_valid at cycles 13 and 14.
- Stray inputs:
  - start outside IDLE is ignored.
  - rd_valid outside WAIT is ignored.
  - A third beat in WAIT cannot occur, because the transition happens on beat 1.
- ena=0 freezes REQ/OUT progression and keeps burst/addr stable, while words still arriving in WAIT are captured.
- Reset mid-operation returns to IDLE with all outputs zero. Hub beats for the aborted request are ignored. The hub is required to flush on reset.
- Arithmetic is unsigned and truncated to `ext_buf_mem_addr_width.

Test Plan:
1. W=2, H=2, pic=0, luma, tile (1,1), ready=1 -> bursts at addr 136, 168, 200, 232, each with len_minus1=1, at cycles 1, 4, 7, 10; out_valid at cycles 13 and 14.
2. Same geometry, pic=3, cr, tile (0,1) -> addr 5952, 5968, 5984, 6000.
3. Words 0x03020100/0x13121110 for row 0 through 0x33323130/0x43424140 for row 3 (row r: left 0x{r}3{r}2{r}1{r}0 pattern) -> left block out_0=0x00, out_3=0x03, out_15=0x33; right block out_0=0x10, out_15=0x43.
4. ready=0 for 5 cycles on burst 2 -> burst and addr held constant, a single acceptance, no extra bursts, and data integrity intact.
5. Second start while busy, plus ena=0 for 3 cycles during OUT0 -> second start is ignored, out_valid is delayed 3 cycles, and exactly two pulses occur.
6. rst_n low during WAIT of row 1, then a new request after release -> all outputs are 0 during reset, and the new request's addresses and data are correct with no stale beats captured.
